sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-ported synchronous SRAM between the CPU instruction-fetch requester and the load/store requester. The block grants at most one access per cycle and drives the SRAM port. It returns read data and completion to the owning requester one cycle later. It sits between the multi-cycle core (IF and MEM states) and the unified inst/data SRAM, so the core can run against a single-port memory model.

## Interface
Parameters:
- ADDR_W, 32, SRAM byte-address width
- STARVE_LIMIT, 4, maximum consecutive data grants while inst_req is pending (fixed-priority mode only); legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held with inst_addr stable until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle (1-cycle pulse)
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request; held stable until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store accepted this cycle
- data_data_ok  out  1  load data valid / store complete (1-cycle pulse)
- data_rdata  out  32  load data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

## Operation
- Grant logic is combinational on the current requests and the registered arbitration state.
  - The granted requester sees addr_ok=1 in the same cycle.
  - sram_en=1, sram_addr=granted addr.
  - sram_we = data_wstrb if the data requester is granted and data_wr=1, else 4'b0.
  - sram_wdata=data_wdata.
- At most one addr_ok is high per cycle. With no request, sram_en=0 and sram_we=0.
- Registered response state:
  - resp_vld (1 bit) is set to 1 on any grant, else cleared to 0.
  - resp_own (0=inst, 1=data) records the owner of the granted access.
- When resp_vld=1, the owner's data_ok=1. Both rdata outputs pass sram_rdata through unregistered. Stores also pulse data_data_ok (write completion).
- A new grant is allowed in the same cycle as a response, giving 1 access/cycle throughput. There is no response backpressure; requesters must accept data_ok when it fires.
- data_wr=1 with data_wstrb=0: an access is issued with sram_we=0, completion is returned, and no write occurs.
- Fixed-priority mode (default):
  - data wins conflicts.
  - 4-bit starve_cnt increments on each data grant while inst_req=1.
  - starve_cnt clears on any inst grant, or when inst_req=0.
  - When starve_cnt==STARVE_LIMIT and both requesters are asking, inst wins.
- Arbitration state: resp_vld, resp_own, starve_cnt, last_own.

## Timing
- Reset values:
  - all outputs 0 (inst_rdata/data_rdata follow sram_rdata only when data_ok=1, else 32'b0)
  - resp_vld=0, starve_cnt=0, last_own=inst
- Latency: request accepted in cycle N produces data_ok in cycle N+1. The SRAM write takes effect at the clk edge ending cycle N.
- Simultaneous requests are resolved in one cycle; the loser's addr_ok=0 and it must hold its request.
- Reset asserted mid-access: resp_vld clears immediately (asynchronous), and the pending data_ok is dropped. A write already clocked into the SRAM is not undone.
- Reset release: the first grant may occur in the first cycle after deassertion.

## Configuration
- SRAM_ARB_RR_EN defined: on conflict, the requester not granted last wins (last_own updates on every grant). STARVE_LIMIT and starve_cnt are unused; starve_cnt is held at 0.
- SRAM_ARB_RR_EN undefined: fixed data priority with the STARVE_LIMIT escape described above.

## Test plan
- Single fetch:
  - Stimulus: inst_req=1, inst_addr=0x1c000000, SRAM word 0x02800c0c.
  - Required: cycle N inst_addr_ok=1, sram_en=1, sram_we=0; cycle N+1 inst_data_ok=1, inst_rdata=0x02800c0c.
- Store then load, back-to-back:
  - Stimulus: store to 0x1c000100 with wstrb=4'b0011, wdata=0xdeadbeef over old word 0x11223344, then load from the same address.
  - Required: second-cycle data_rdata=0x1122beef, one data_data_ok per access.
- Conflict, fixed mode, STARVE_LIMIT=4:
  - Stimulus: inst_req and data_req both held high.
  - Required: grants D,D,D,D,I,D,D,D,D,I; no inst_addr_ok before the 5th cycle.
- Conflict with SRAM_ARB_RR_EN:
  - Stimulus: both requests held high from reset.
  - Required: grants alternate I,D,I,D, first grant I.
- Reset mid-access:
  - Stimulus: assert reset half a cycle after a load grant.
  - Required: data_data_ok never fires, all outputs 0 while reset=1, normal grant on the first cycle after release.
- Zero-strobe store:
  - Stimulus: data_wr=1, data_wstrb=0.
  - Required: sram_we=0, SRAM contents unchanged, data_data_ok=1 at N+1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-ported synchronous SRAM between the instruction-fetch
// requester and the load/store requester. At most one access is granted per
// cycle; the granted requester sees addr_ok in the same cycle and its
// data_ok (with read data passed straight through from the SRAM) one cycle
// later.
//
// Build option:
//   SRAM_ARB_RR_EN  - when defined, conflicts are resolved round-robin
//                     (the requester not granted last wins). When undefined,
//                     data has fixed priority, with an escape that hands one
//                     grant to a starving fetch after STARVE_LIMIT
//                     consecutive data grants.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // Owner encoding for the response and round-robin state.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Registered response state: an access granted this cycle answers next cycle.
    logic resp_vld_r;
    logic resp_own_r;

    // Combinational grant decisions.
    logic grant_inst_s;
    logic grant_data_s;
    logic data_wins_s;   // conflict winner when both requesters ask

`ifdef SRAM_ARB_RR_EN
    // Round-robin state. Until the first grant after reset the fetch side is
    // preferred, so the core's first instruction fetch is never delayed.
    logic last_own_r;
    logic rr_seen_r;
`else
    // Consecutive data grants while a fetch has been waiting.
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_nxt_s;
`endif

    // ------------------------------------------------------------------
    // Conflict resolution
    // ------------------------------------------------------------------

`ifdef SRAM_ARB_RR_EN
    // Round-robin: the side that did not win the previous grant wins now.
    always_comb begin
        data_wins_s = 1'b1;
        if (!rr_seen_r) begin
            data_wins_s = 1'b0;
        end else if (last_own_r == OWN_DATA) begin
            data_wins_s = 1'b0;
        end else begin
            data_wins_s = 1'b1;
        end
    end
`else
    // Fixed priority: data wins unless the fetch has waited STARVE_LIMIT grants.
    always_comb begin
        data_wins_s = 1'b1;
        if (starve_cnt_r == STARVE_LIMIT_C) begin
            data_wins_s = 1'b0;
        end else begin
            data_wins_s = 1'b1;
        end
    end
`endif

    // Select at most one requester this cycle; nothing is granted in reset.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (reset) begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end else if (inst_req && data_req) begin
            grant_data_s = data_wins_s;
            grant_inst_s = !data_wins_s;
        end else if (data_req) begin
            grant_data_s = 1'b1;
        end else if (inst_req) begin
            grant_inst_s = 1'b1;
        end else begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // SRAM port
    // ------------------------------------------------------------------

    // Drive the SRAM from the granted requester; stores use the byte strobes.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = {ADDR_W{1'b0}};
        sram_wdata = 32'h0000_0000;
        if (grant_data_s) begin
            sram_en   = 1'b1;
            sram_addr = data_addr;
            if (data_wr) begin
                // A zero strobe still issues an access, it just writes nothing.
                sram_we = data_wstrb;
            end else begin
                sram_we = 4'b0000;
            end
        end else if (grant_inst_s) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
            sram_we   = 4'b0000;
        end else begin
            sram_en   = 1'b0;
            sram_addr = {ADDR_W{1'b0}};
            sram_we   = 4'b0000;
        end
        // Write data follows the data requester whenever not in reset.
        if (reset) begin
            sram_wdata = 32'h0000_0000;
        end else begin
            sram_wdata = data_wdata;
        end
    end

    assign inst_addr_ok = grant_inst_s;
    assign data_addr_ok = grant_data_s;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------

    // Record that an access was issued and who owns its answer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_vld_r <= 1'b0;
            resp_own_r <= OWN_INST;
        end else begin
            resp_vld_r <= grant_inst_s | grant_data_s;
            if (grant_data_s) begin
                resp_own_r <= OWN_DATA;
            end else if (grant_inst_s) begin
                resp_own_r <= OWN_INST;
            end else begin
                resp_own_r <= resp_own_r;
            end
        end
    end

    // Completion pulses go to the owner; read data is only visible with data_ok.
    assign inst_data_ok = resp_vld_r && (resp_own_r == OWN_INST);
    assign data_data_ok = resp_vld_r && (resp_own_r == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0000_0000;
    assign data_rdata   = data_data_ok ? sram_rdata : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Arbitration history
    // ------------------------------------------------------------------

`ifdef SRAM_ARB_RR_EN
    // Track the owner of the most recent grant for round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_own_r <= OWN_INST;
            rr_seen_r  <= 1'b0;
        end else if (grant_data_s) begin
            last_own_r <= OWN_DATA;
            rr_seen_r  <= 1'b1;
        end else if (grant_inst_s) begin
            last_own_r <= OWN_INST;
            rr_seen_r  <= 1'b1;
        end else begin
            last_own_r <= last_own_r;
            rr_seen_r  <= rr_seen_r;
        end
    end
`else
    // Next starvation count: reset when the fetch is served or stops asking.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (grant_inst_s || !inst_req) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (grant_data_s && (starve_cnt_r != 4'hF)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios followed by randomized
// traffic, checked against a behavioural model of the arbitration rules and
// a reference copy of the memory contents.
module tb_sram_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int G_NONE = 0;
    localparam int G_INST = 1;
    localparam int G_DATA = 2;
    localparam logic [31:0] RBASE = 32'h1c00_0200;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Memory behind the DUT, and the bench's own expectation of its contents.
    logic [31:0] sram_mem [int unsigned];
    logic [31:0] ref_mem  [int unsigned];

    // Reference model state.
    int          m_streak;      // consecutive data grants while fetch waits
    bit          m_rr_seen;     // any grant since reset (round-robin build)
    bit          m_last_data;   // last grant went to data (round-robin build)
    bit          m_rsp_vld;
    bit          m_rsp_data;
    bit          m_rsp_load;
    logic [31:0] m_rsp_rdata;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM; returns garbage when not enabled.
    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (sram_en) begin
            w = sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : 32'h0;
            sram_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[sram_addr[31:2]] = w;
        end else begin
            sram_rdata <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        sram_mem[a[31:2]] = v;
        ref_mem[a[31:2]]  = v;
    endtask

    task automatic model_reset();
        m_streak = 0; m_rr_seen = 0; m_last_data = 0;
        m_rsp_vld = 0; m_rsp_data = 0; m_rsp_load = 0; m_rsp_rdata = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
        chk({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
        chk({tag, "_inst_rdata"},   inst_rdata,   32'h0);
        chk({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
        chk({tag, "_data_data_ok"}, data_data_ok, 1'b0);
        chk({tag, "_data_rdata"},   data_rdata,   32'h0);
        chk({tag, "_sram_en"},      sram_en,      1'b0);
        chk({tag, "_sram_we"},      sram_we,      4'h0);
        chk({tag, "_sram_addr"},    sram_addr,    32'h0);
        chk({tag, "_sram_wdata"},   sram_wdata,   32'h0);
    endtask

    // One clock cycle: drive requests, check every output against the model,
    // then advance the model past the coming edge. gobs is the DUT's grant.
    task automatic cycle(input bit ireq, input logic [31:0] iaddr,
                         input bit dreq, input bit dwr, input logic [3:0] dstrb,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         output int gobs);
        int g;
        logic [31:0] w;
        @(negedge clk);
        inst_req = ireq; inst_addr = iaddr;
        data_req = dreq; data_wr = dwr; data_wstrb = dstrb;
        data_addr = daddr; data_wdata = dwdata;
        #2;
        if (ireq && dreq) begin
`ifdef SRAM_ARB_RR_EN
            g = (m_rr_seen && !m_last_data) ? G_DATA : G_INST;
`else
            g = (m_streak == STARVE_LIMIT) ? G_INST : G_DATA;
`endif
        end else if (dreq) g = G_DATA;
        else if (ireq) g = G_INST;
        else g = G_NONE;
        gobs = inst_addr_ok ? G_INST : (data_addr_ok ? G_DATA : G_NONE);

        chk("inst_addr_ok", inst_addr_ok, g == G_INST);
        chk("data_addr_ok", data_addr_ok, g == G_DATA);
        chk("sram_en", sram_en, g != G_NONE);
        chk("sram_we", sram_we, (g == G_DATA && dwr) ? dstrb : 4'h0);
        if (g == G_INST) chk("sram_addr_i", sram_addr, iaddr);
        else if (g == G_DATA) chk("sram_addr_d", sram_addr, daddr);
        chk("sram_wdata", sram_wdata, dwdata);
        chk("inst_data_ok", inst_data_ok, m_rsp_vld && !m_rsp_data);
        chk("data_data_ok", data_data_ok, m_rsp_vld && m_rsp_data);
        chk("inst_rdata", inst_rdata, (m_rsp_vld && !m_rsp_data) ? m_rsp_rdata : 32'h0);
        if (!(m_rsp_vld && m_rsp_data && !m_rsp_load))
            chk("data_rdata", data_rdata, (m_rsp_vld && m_rsp_data) ? m_rsp_rdata : 32'h0);

        m_rsp_vld  = (g != G_NONE);
        m_rsp_data = (g == G_DATA);
        m_rsp_load = (g == G_DATA) && !dwr;
        if (g == G_INST) m_rsp_rdata = ref_rd(iaddr);
        else if (g == G_DATA) begin
            m_rsp_rdata = ref_rd(daddr);
            if (dwr) begin
                w = ref_rd(daddr);
                for (int b = 0; b < 4; b++)
                    if (dstrb[b]) w[8*b +: 8] = dwdata[8*b +: 8];
                ref_mem[daddr[31:2]] = w;
            end
        end
        if (g == G_INST || !ireq) m_streak = 0;
        else if (g == G_DATA) m_streak++;
        if (g != G_NONE) begin
            m_rr_seen = 1;
            m_last_data = (g == G_DATA);
        end
    endtask

    initial begin
        int go;
        int exp_pat [10];
        bit ip, dp, dw;
        logic [31:0] ia, da, dwd;
        logic [3:0] ds;

        reset = 1'b1;
        inst_req = 0; inst_addr = 32'h0; data_req = 0; data_wr = 0;
        data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        model_reset();
        preload(32'h1c00_0000, 32'h0280_0c0c);
        preload(32'h1c00_0100, 32'h1122_3344);
        for (int k = 0; k < 8; k++) preload(RBASE + 32'(4 * k), $urandom);

        // Reset state.
        @(negedge clk); #2;
        chk_all_zero("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch.
        cycle(1, 32'h1c00_0000, 0, 0, 4'h0, 32'h0, 32'h0, go);
        chk("fetch_grant", go, G_INST);
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);
        chk("fetch_rdata", inst_rdata, 32'h0280_0c0c);

        // Store then load, back to back.
        cycle(0, 32'h0, 1, 1, 4'b0011, 32'h1c00_0100, 32'hdead_beef, go);
        cycle(0, 32'h0, 1, 0, 4'h0, 32'h1c00_0100, 32'hdead_beef, go);
        chk("store_done", data_data_ok, 1'b1);
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);
        chk("st_ld_rdata", data_rdata, 32'h1122_beef);

        // Zero-strobe store leaves memory unchanged but still completes.
        cycle(0, 32'h0, 1, 1, 4'b0000, 32'h1c00_0100, 32'hcafe_f00d, go);
        chk("zs_we", sram_we, 4'h0);
        cycle(0, 32'h0, 1, 0, 4'h0, 32'h1c00_0100, 32'h0, go);
        chk("zs_done", data_data_ok, 1'b1);
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);
        chk("zs_unchanged", data_rdata, 32'h1122_beef);

        // Reset half a cycle after a load grant: its completion is dropped.
        cycle(0, 32'h0, 1, 0, 4'h0, 32'h1c00_0000, 32'h0, go);
        chk("rm_grant", go, G_DATA);
        #2;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #2;
            chk_all_zero("rm");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(0, 32'h0, 1, 0, 4'h0, 32'h1c00_0000, 32'h0, go);
        chk("rm_first_grant", go, G_DATA);
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);

        // Conflict from reset with both requests held.
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef SRAM_ARB_RR_EN
        exp_pat = '{G_INST, G_DATA, G_INST, G_DATA, G_INST, G_DATA, G_INST, G_DATA, G_INST, G_DATA};
`else
        exp_pat = '{G_DATA, G_DATA, G_DATA, G_DATA, G_INST, G_DATA, G_DATA, G_DATA, G_DATA, G_INST};
`endif
        for (int k = 0; k < 10; k++) begin
            cycle(1, 32'h1c00_0000, 1, 0, 4'h0, 32'h1c00_0100, 32'h0, go);
            chk($sformatf("conflict_grant_%0d", k), go, exp_pat[k]);
        end
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);

        // Randomized traffic; each requester holds its request until accepted.
        ip = 0; dp = 0; ia = RBASE; da = RBASE; dw = 0; ds = 4'h0; dwd = 32'h0;
        repeat (400) begin
            if (!ip && $urandom_range(0, 99) < 60) begin
                ip = 1;
                ia = RBASE + 32'(4 * $urandom_range(0, 7));
            end
            if (!dp && $urandom_range(0, 99) < 60) begin
                dp = 1;
                da = RBASE + 32'(4 * $urandom_range(0, 7));
                dw = 1'($urandom_range(0, 1));
                ds = 4'($urandom);
                dwd = $urandom;
            end
            cycle(ip, ia, dp, dw, ds, da, dwd, go);
            if (go == G_INST) ip = 0;
            if (go == G_DATA) dp = 0;
        end
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);
        cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, go);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
